// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter and access sequencer in front of the byte-addressed data memory.
// Port 0 is the CPU load/store unit, port 1 the debug/DMA loader; one transaction every two cycles.
module data_mem_arbiter #(
   parameter int ADDRESS_WIDTH = 17,
   parameter int DATA_WIDTH    = 32
) (
   input  logic                     CLK,
   input  logic                     RST,
   input  logic                     REQ0,
   input  logic                     WEN0,
   input  logic [1:0]               SIZE0,
   input  logic                     UNS0,
   input  logic [ADDRESS_WIDTH-1:0] ADDR0,
   input  logic [DATA_WIDTH-1:0]    WDATA0,
   input  logic                     REQ1,
   input  logic                     WEN1,
   input  logic [1:0]               SIZE1,
   input  logic                     UNS1,
   input  logic [ADDRESS_WIDTH-1:0] ADDR1,
   input  logic [DATA_WIDTH-1:0]    WDATA1,
   output logic                     GNT0,
   output logic                     GNT1,
   output logic                     RVALID0,
   output logic                     RVALID1,
   output logic [DATA_WIDTH-1:0]    RDATA,
   output logic                     ERR,
   output logic                     MEM_WE0,
   output logic                     MEM_WE1,
   output logic                     MEM_WE2,
   output logic                     MEM_WE3,
   output logic [ADDRESS_WIDTH-1:0] MEM_A,
   output logic [DATA_WIDTH-1:0]    MEM_WD,
   input  logic [DATA_WIDTH-1:0]    MEM_RD
);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t                   state, state_next;
   logic                     last_grant;
   logic                     grant_any;
   logic                     grant_port;
   logic                     lat_port;
   logic                     lat_wen;
   logic                     lat_uns;
   logic [1:0]               lat_size;
   logic [ADDRESS_WIDTH-1:0] lat_addr;
   logic [DATA_WIDTH-1:0]    lat_wdata;
   logic [3:0]               we_mask;
   logic                     we_enable;
   logic [DATA_WIDTH-1:0]    load_ext;

   // Arbitration and next state; on a tie the port that did not win last time is served.
   always_comb begin
      state_next = state;
      grant_any  = 1'b0;
      grant_port = 1'b0;
      GNT0       = 1'b0;
      GNT1       = 1'b0;
      case (state)
         IDLE: begin
            if (!RST) begin
               if (REQ0 && REQ1) begin
                  grant_any  = 1'b1;
                  grant_port = ~last_grant;
               end else if (REQ0) begin
                  grant_any  = 1'b1;
                  grant_port = 1'b0;
               end else if (REQ1) begin
                  grant_any  = 1'b1;
                  grant_port = 1'b1;
               end
               if (grant_any) begin
                  GNT0       = ~grant_port;
                  GNT1       = grant_port;
                  state_next = ACCESS;
               end
            end
         end
         ACCESS: state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Byte lane mask; RST gates it directly so a reset during ACCESS never commits a partial store.
   always_comb begin
      we_mask = 4'b0000;
      case (lat_size)
         2'b00:   we_mask = 4'b0001;
         2'b01:   we_mask = 4'b0011;
         2'b10:   we_mask = 4'b1111;
         default: we_mask = 4'b0000;
      endcase
   end

   assign we_enable = (state == ACCESS) && lat_wen && !RST;
   assign MEM_WE0   = we_enable && we_mask[0];
   assign MEM_WE1   = we_enable && we_mask[1];
   assign MEM_WE2   = we_enable && we_mask[2];
   assign MEM_WE3   = we_enable && we_mask[3];
   assign MEM_A     = lat_addr;
   assign MEM_WD    = lat_wdata;

   always_comb begin
      load_ext = '0;
      case (lat_size)
         2'b00:   load_ext = {{24{~lat_uns & MEM_RD[7]}}, MEM_RD[7:0]};
         2'b01:   load_ext = {{16{~lat_uns & MEM_RD[15]}}, MEM_RD[15:0]};
         2'b10:   load_ext = MEM_RD;
         default: load_ext = '0;
      endcase
   end

   // Request latch on grant, response registers on the ACCESS edge.
   always_ff @(posedge CLK) begin
      if (RST) begin
         state      <= IDLE;
         last_grant <= 1'b1;
         lat_port   <= 1'b0;
         lat_wen    <= 1'b0;
         lat_uns    <= 1'b0;
         lat_size   <= 2'b00;
         lat_addr   <= '0;
         lat_wdata  <= '0;
         RVALID0    <= 1'b0;
         RVALID1    <= 1'b0;
         ERR        <= 1'b0;
         RDATA      <= '0;
      end else begin
         state   <= state_next;
         RVALID0 <= 1'b0;
         RVALID1 <= 1'b0;
         ERR     <= 1'b0;
         if (grant_any) begin
            last_grant <= grant_port;
            lat_port   <= grant_port;
            lat_wen    <= grant_port ? WEN1   : WEN0;
            lat_size   <= grant_port ? SIZE1  : SIZE0;
            lat_uns    <= grant_port ? UNS1   : UNS0;
            lat_addr   <= grant_port ? ADDR1  : ADDR0;
            lat_wdata  <= grant_port ? WDATA1 : WDATA0;
         end
         if (state == ACCESS) begin
            RDATA   <= lat_wen ? '0 : load_ext;
            ERR     <= (lat_size == 2'b11);
            RVALID0 <= ~lat_port;
            RVALID1 <= lat_port;
         end
      end
   end

endmodule

// File: doc/data_mem_arbiter.md
Name: data_mem_arbiter

Overview:
- Two-port round-robin arbiter and access sequencer in front of the byte-addressed data memory (byte write enables WE0..WE3, combinational read RD).
- Port 0 = CPU load/store unit; port 1 = debug/DMA loader.
- Decodes access size into byte enables, registers each accepted request, drives one memory access, returns registered, sign/zero-extended read data with a completion pulse.

Parameters:
- ADDRESS_WIDTH, 17, byte address width of the data memory.
- DATA_WIDTH, 32, data word width; fixed at 32 (4 byte lanes).

Ports:
- CLK  in  1  clock; all state updates on rising edge.
- RST  in  1  synchronous active-high reset.
- REQ0 / REQ1  in  1  request valid, ports 0/1.
- WEN0 / WEN1  in  1  1 = store, 0 = load.
- SIZE0 / SIZE1  in  2  00 byte, 01 half, 10 word, 11 reserved.
- UNS0 / UNS1  in  1  1 = zero-extend loads, 0 = sign-extend.
- ADDR0 / ADDR1  in  ADDRESS_WIDTH  byte address.
- WDATA0 / WDATA1  in  DATA_WIDTH  store data, LSB-aligned.
- GNT0 / GNT1  out  1  request accepted this cycle (combinational).
- RVALID0 / RVALID1  out  1  one-cycle completion pulse (loads and stores).
- RDATA  out  DATA_WIDTH  extended load data; 0 for stores and errors.
- ERR  out  1  valid with RVALID; 1 = reserved SIZE.
- MEM_WE0..MEM_WE3  out  1 each  byte write enables to memory.
- MEM_A  out  ADDRESS_WIDTH  memory byte address.
- MEM_WD  out  DATA_WIDTH  memory write data.
- MEM_RD  in  DATA_WIDTH  memory read data (combinational from MEM_A).

Behaviour:
- Reset: state = IDLE, last_grant = 1 (port 0 wins first tie); GNTx, RVALIDx, ERR = 0; RDATA = 0; MEM_A = 0; MEM_WD = 0; MEM_WEx = 0.
- FSM IDLE -> ACCESS -> IDLE. One transaction per 2 cycles.
- IDLE:
  - Only one REQ high: grant that port.
  - Both high: grant the port != last_grant.
  - GNTx asserted combinationally in the same cycle.
  - At the edge: latch port id, WEN, SIZE, UNS, ADDR, WDATA; update last_grant; go to ACCESS.
  - No REQ: GNT = 0; stay in IDLE.
- ACCESS:
  - GNT0 = GNT1 = 0, regardless of REQ.
  - MEM_A = latched ADDR; MEM_WD = latched WDATA.
  - MEM_WEx = byte mask when latched WEN = 1, SIZE valid, and RST = 0. Masks: SIZE 00 -> WE0; 01 -> WE0, WE1; 10 -> WE0..WE3; 11 -> none.
  - MEM_WEx = 0 in IDLE.
  - At the edge: RDATA <= extended MEM_RD for loads, 0 for stores or SIZE 11. ERR <= (SIZE == 11). RVALID of the latched port <= 1. Go to IDLE.
- Load extension:
  - byte: RD[7:0], bits [31:8] = UNS ? 0 : RD[7].
  - half: RD[15:0], bits [31:16] = UNS ? 0 : RD[15].
  - word: RD unchanged.
- Latency: GNT in cycle N; memory access in N+1 (store commits at end of N+1); RVALID and RDATA valid in N+2.
- RVALIDx and ERR are high exactly one cycle. RDATA holds its value until the next completion.
- In the RVALID cycle the FSM is in IDLE and may grant a new request (back-to-back).
- MEM_A / MEM_WD hold the last latched values while in IDLE.
- Requester rules:
  - Holds REQ and fields stable until GNT.
  - May drop REQ or present the next request the cycle after GNT.
  - Must not rely on GNT in the cycle after a grant.
- Misaligned addresses: allowed, passed through unchanged; address wrap at 2^ADDRESS_WIDTH is handled by the memory.
- Reset mid-operation: RST high in ACCESS gates MEM_WEx to 0 combinationally, so no partial store commits. The transaction is dropped with no RVALID. Next cycle all outputs are at reset values.
- Fairness: with both ports requesting continuously, grants alternate 0, 1, 0, 1…

Test Plan:
- Port-0 store word: ADDR0 = 0x100, WDATA0 = 0xDEADBEEF, SIZE 10 -> GNT0 at N; MEM_WE0..3 = 1111 at N+1; RVALID0 at N+2, RDATA = 0. Then load word 0x100 -> RDATA = 0xDEADBEEF.
- Byte/half extension: memory[0x200..0x203] = 80 FF 7F 00.
  - lb 0x200 -> 0xFFFFFF80; lbu -> 0x00000080.
  - lh 0x200 -> 0xFFFFFF80; lhu 0x200 -> 0x0000FF80.
  - lh 0x201 -> 0x00007FFF (misaligned).
- Partial store: sb 0x300 data 0x000000AA over 0x11223344 -> lw reads 0x112233AA. sh -> only WE0, WE1 pulse.
- Arbitration: REQ0 and REQ1 both held high for 8 cycles from reset -> grants 0, 1, 0, 1 at cycles 0, 2, 4, 6. GNT never high in ACCESS cycles. RVALID goes to the matching port 2 cycles after each grant.
- Reserved SIZE 11 store to 0x400 -> no MEM_WE pulse; RVALID with ERR = 1, RDATA = 0. Memory at 0x400 unchanged.
- Reset in ACCESS of sw 0x500 = 0xCAFEF00D -> MEM_WEx stay 0, no RVALID, memory unchanged. After reset, port 0 wins a simultaneous request.
